// File: rtl/calc_pkg.sv
// calc_pkg: shared FSM state, op encodings and width defaults for the calculator sequencer
package calc_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int SW_W_DEF = 16;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b1000;
  typedef enum logic [2:0] {S_IDLE, S_PUSH, S_POP1, S_POP2, S_CAP, S_EXEC, S_WB, S_ERR} state_t;
endpackage

// File: rtl/calc_sequencer_btn_edge_arb.sv
// btn_edge_arb: rising-edge detect on debounced buttons, lowest index wins, all edges dropped while busy
module btn_edge_arb #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] i_btn,
  input  logic         i_busy,
  output logic         o_valid,
  output logic [N-1:0] o_cmd
);
  logic [N-1:0] r_prev, w_rise;
  always_ff @(posedge clk) r_prev <= rst ? '0 : i_btn;
  always_comb begin
    w_rise = i_btn & ~r_prev;
    o_cmd = i_busy ? '0 : w_rise & (~w_rise + N'(1));
    o_valid = |o_cmd;
  end
endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: turns button edges into push/pop/exec/write-back sequences for the stack/queue calculator
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SW_W = SW_W_DEF,
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        btn_db,
  input  logic              stack_queue,
  input  logic [SW_W-1:0]   switches,
  input  logic [CNT_W-1:0]  mem_count,
  input  logic              mem_full,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_push,
  output logic              mem_pop,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_y,
  output logic [DATA_W-1:0] disp_val,
  output logic              busy,
  output logic              err_under,
  output logic              err_over
);
  state_t r_state, w_next;
  logic w_valid;
  logic [4:0] w_cmd;
  logic [DATA_W-1:0] r_p1, r_a, r_b, r_disp, w_sw;
  logic [3:0] r_op;
  logic r_stack, r_err_under, r_err_over;
  assign w_sw = {{(DATA_W-SW_W){1'b0}}, switches};
  assign busy = r_state != S_IDLE;
  assign alu_a = r_a;
  assign alu_b = r_b;
  assign disp_val = r_disp;
  assign err_under = r_err_under;
  assign err_over = r_err_over;
  btn_edge_arb #(.N(5)) u_arb (
    .clk(clk), .rst(rst), .i_btn(btn_db), .i_busy(busy), .o_valid(w_valid), .o_cmd(w_cmd)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: w_next = !w_valid ? S_IDLE : w_cmd[0] ? (mem_full ? S_ERR : S_PUSH)
                     : (mem_count < CNT_W'(2) ? S_ERR : S_POP1);
      S_POP1: w_next = S_POP2;
      S_POP2: w_next = S_CAP;
      S_CAP: w_next = S_EXEC;
      S_EXEC: w_next = S_WB;
      default: w_next = S_IDLE;
    endcase
    mem_push = r_state == S_PUSH || r_state == S_WB;
    mem_pop = r_state == S_POP1 || r_state == S_POP2;
    mem_wdata = r_state == S_PUSH ? w_sw : r_state == S_WB ? alu_y : '0;
    alu_op = (r_state == S_EXEC || r_state == S_WB) ? r_op : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_p1 <= '0;
      r_a <= '0;
      r_b <= '0;
      r_disp <= '0;
      r_op <= '0;
      r_stack <= 1'b0;
      r_err_under <= 1'b0;
      r_err_over <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_valid) begin
        r_op <= w_cmd[4:1];
        r_stack <= stack_queue;
        r_err_over <= w_next == S_ERR ? r_err_over | w_cmd[0] : 1'b0;
        r_err_under <= w_next == S_ERR ? r_err_under | ~w_cmd[0] : 1'b0;
      end
      if (r_state == S_POP2) r_p1 <= mem_rdata;
      if (r_state == S_CAP) begin
        r_a <= r_stack ? mem_rdata : r_p1;
        r_b <= r_stack ? r_p1 : mem_rdata;
      end
      if (mem_push) r_disp <= mem_wdata;
    end
  end
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: table, timing-sequence and randomized checks of calc_sequencer against a storage/ALU model
module tb_calc_sequencer;
  import calc_pkg::*;
  localparam int DEPTH = 8;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] btn_db = '0;
  logic stack_queue = 1'b1;
  logic [15:0] switches = '0;
  logic [3:0] mem_count = '0;
  logic mem_full, force_full = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] mem_wdata, alu_a, alu_b, alu_y, disp_val;
  logic mem_push, mem_pop, busy, err_under, err_over;
  logic [3:0] alu_op;
  logic [31:0] mem[$];
  logic [31:0] model_q[$];
  logic [31:0] exp_disp, exp_a, exp_b;
  logic exp_eu, exp_eo;
  int checks = 0, errors = 0;
  typedef struct {
    int idx; logic sq; logic [15:0] sw;
    logic [31:0] disp, a, b; logic eu, eo; int cnt;
  } vec_t;
  vec_t tbl[10];

  always #5 clk = ~clk;

  calc_sequencer dut (
    .clk(clk), .rst(rst), .btn_db(btn_db), .stack_queue(stack_queue), .switches(switches),
    .mem_count(mem_count), .mem_full(mem_full), .mem_rdata(mem_rdata),
    .mem_push(mem_push), .mem_pop(mem_pop), .mem_wdata(mem_wdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y),
    .disp_val(disp_val), .busy(busy), .err_under(err_under), .err_over(err_over)
  );

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    return op == OP_ADD ? a + b : op == OP_SUB ? a - b : op == OP_AND ? a & b : op == OP_OR ? a | b : '0;
  endfunction

  assign alu_y = alu_f(alu_a, alu_b, alu_op);
  assign mem_full = force_full || mem_count >= 4'(DEPTH);

  always @(posedge clk) begin
    if (rst) begin
      mem.delete();
      mem_count <= '0;
      mem_rdata <= '0;
    end else begin
      if (mem_push) mem.push_back(mem_wdata);
      if (mem_pop && mem.size() > 0) begin
        mem_rdata <= stack_queue ? mem[$] : mem[0];
        if (stack_queue) void'(mem.pop_back());
        else void'(mem.pop_front());
      end
      mem_count <= 4'(mem.size());
    end
  end

  always @(negedge clk)
    if (mem_push && mem_pop) begin
      errors++;
      $display("FAIL push_pop_overlap: got push=1 pop=1 required never both");
    end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic press(input logic [4:0] b, input logic sq, input logic [15:0] sw);
    @(negedge clk);
    stack_queue = sq;
    switches = sw;
    btn_db = b;
  endtask

  task automatic do_cmd(input int idx, input logic sq, input logic [15:0] sw);
    press(5'(1 << idx), sq, sw);
    @(negedge clk);
    btn_db = '0;
    wait_idle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    btn_db = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_q.delete();
    exp_disp = '0; exp_a = '0; exp_b = '0; exp_eu = 1'b0; exp_eo = 1'b0;
  endtask

  task automatic model_cmd(input int idx, input logic sq, input logic [15:0] sw);
    logic [31:0] a, b;
    if (idx == 0) begin
      if (model_q.size() >= DEPTH) exp_eo = 1'b1;
      else begin
        model_q.push_back({16'h0, sw});
        exp_disp = {16'h0, sw};
        exp_eu = 1'b0;
        exp_eo = 1'b0;
      end
    end else if (model_q.size() < 2) exp_eu = 1'b1;
    else begin
      if (sq) begin
        b = model_q.pop_back();
        a = model_q.pop_back();
      end else begin
        a = model_q.pop_front();
        b = model_q.pop_front();
      end
      exp_a = a;
      exp_b = b;
      exp_disp = alu_f(a, b, 4'(1 << (idx - 1)));
      model_q.push_back(exp_disp);
      exp_eu = 1'b0;
      exp_eo = 1'b0;
    end
  endtask

  task automatic chk_state();
    chk("rnd_disp_val", disp_val, exp_disp);
    chk("rnd_alu_a", alu_a, exp_a);
    chk("rnd_alu_b", alu_b, exp_b);
    chk("rnd_err_under", 32'(err_under), 32'(exp_eu));
    chk("rnd_err_over", 32'(err_over), 32'(exp_eo));
    chk("rnd_mem_count", 32'(mem_count), 32'(model_q.size()));
    if (mem.size() == model_q.size())
      foreach (model_q[i]) chk("rnd_mem_data", mem[i], model_q[i]);
  endtask

  initial begin
    int idx, cnt0;
    logic sq;
    logic [15:0] sw;
    tbl = '{
      '{0, 1'b1, 16'h0005, 32'h00000005, 32'h0,        32'h0,        1'b0, 1'b0, 1},
      '{1, 1'b1, 16'h0000, 32'h00000005, 32'h0,        32'h0,        1'b1, 1'b0, 1},
      '{0, 1'b1, 16'h0003, 32'h00000003, 32'h0,        32'h0,        1'b0, 1'b0, 2},
      '{2, 1'b1, 16'h0000, 32'h00000002, 32'h5,        32'h3,        1'b0, 1'b0, 1},
      '{0, 1'b0, 16'h0007, 32'h00000007, 32'h5,        32'h3,        1'b0, 1'b0, 2},
      '{2, 1'b0, 16'h0000, 32'hFFFFFFFB, 32'h2,        32'h7,        1'b0, 1'b0, 1},
      '{0, 1'b0, 16'hFFFF, 32'h0000FFFF, 32'h2,        32'h7,        1'b0, 1'b0, 2},
      '{3, 1'b0, 16'h0000, 32'h0000FFFB, 32'hFFFFFFFB, 32'h0000FFFF, 1'b0, 1'b0, 1},
      '{0, 1'b1, 16'h0010, 32'h00000010, 32'hFFFFFFFB, 32'h0000FFFF, 1'b0, 1'b0, 2},
      '{4, 1'b1, 16'h0000, 32'h0000FFFB, 32'h0000FFFB, 32'h00000010, 1'b0, 1'b0, 1}
    };
    btn_db = 5'b00001;
    switches = 16'h0009;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_push_pop", {30'd0, mem_push, mem_pop}, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_disp", disp_val, 32'd0);
    chk("rst_errs", {30'd0, err_under, err_over}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("held_btn_push", 32'(mem_push), 32'd1);
    chk("held_btn_wdata", mem_wdata, 32'h9);
    repeat (3) @(negedge clk);
    chk("held_btn_once", 32'(mem_count), 32'd1);
    btn_db = '0;
    do_reset();
    press(5'b00001, 1'b1, 16'h0005);
    @(negedge clk);
    btn_db = '0;
    chk("push_strobe", 32'(mem_push), 32'd1);
    chk("push_wdata", mem_wdata, 32'h5);
    chk("push_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("push_done_busy", 32'(busy), 32'd0);
    chk("push_disp", disp_val, 32'h5);
    do_cmd(0, 1'b1, 16'h0003);
    press(5'b00100, 1'b1, 16'h0000);
    @(negedge clk);
    btn_db = '0;
    chk("stk_pop1", {30'd0, mem_pop, mem_push}, 32'd2);
    @(negedge clk);
    chk("stk_pop2", {30'd0, mem_pop, mem_push}, 32'd2);
    @(negedge clk);
    chk("stk_cap", {29'd0, busy, mem_pop, mem_push}, 32'd4);
    @(negedge clk);
    chk("stk_exec_a", alu_a, 32'h5);
    chk("stk_exec_b", alu_b, 32'h3);
    chk("stk_exec_op", 32'(alu_op), 32'(OP_SUB));
    chk("stk_exec_push", 32'(mem_push), 32'd0);
    @(negedge clk);
    chk("stk_wb_push", 32'(mem_push), 32'd1);
    chk("stk_wb_wdata", mem_wdata, 32'h2);
    chk("stk_wb_op", 32'(alu_op), 32'(OP_SUB));
    @(negedge clk);
    chk("stk_idle", 32'(busy), 32'd0);
    chk("stk_disp", disp_val, 32'h2);
    chk("stk_op_idle", 32'(alu_op), 32'd0);
    chk("stk_count", 32'(mem_count), 32'd1);
    do_reset();
    do_cmd(0, 1'b0, 16'h0005);
    do_cmd(0, 1'b0, 16'h0003);
    do_cmd(2, 1'b0, 16'h0000);
    chk("que_alu_a", alu_a, 32'h5);
    chk("que_alu_b", alu_b, 32'h3);
    chk("que_disp", disp_val, 32'h2);
    press(5'b00010, 1'b1, 16'h0000);
    @(negedge clk);
    btn_db = '0;
    chk("under_no_pop", 32'(mem_pop), 32'd0);
    chk("under_flag", 32'(err_under), 32'd1);
    chk("under_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("under_busy_1cyc", 32'(busy), 32'd0);
    chk("under_count", 32'(mem_count), 32'd1);
    do_cmd(0, 1'b1, 16'h0011);
    chk("under_cleared", 32'(err_under), 32'd0);
    force_full = 1'b1;
    press(5'b00001, 1'b1, 16'h0022);
    @(negedge clk);
    btn_db = '0;
    chk("over_no_push", 32'(mem_push), 32'd0);
    chk("over_flag", 32'(err_over), 32'd1);
    @(negedge clk);
    force_full = 1'b0;
    chk("over_count", 32'(mem_count), 32'd2);
    cnt0 = 32'(mem_count);
    press(5'b00101, 1'b1, 16'h0033);
    @(negedge clk);
    btn_db = '0;
    chk("simul_push", {30'd0, mem_push, mem_pop}, 32'd2);
    chk("simul_over_cleared", 32'(err_over), 32'd0);
    repeat (3) @(negedge clk);
    chk("simul_idle", 32'(busy), 32'd0);
    chk("simul_count", 32'(mem_count), 32'(cnt0 + 1));
    chk("simul_disp", disp_val, 32'h33);
    press(5'b00100, 1'b1, 16'h0000);
    @(negedge clk);
    btn_db = '0;
    @(negedge clk);
    btn_db = 5'b00010;
    @(negedge clk);
    btn_db = '0;
    wait_idle();
    repeat (3) begin
      @(negedge clk);
      chk("busy_drop_idle", 32'(busy), 32'd0);
    end
    chk("busy_drop_count", 32'(mem_count), 32'(cnt0));
    chk("busy_drop_disp", disp_val, 32'h00000011 - 32'h00000033);
    press(5'b00010, 1'b1, 16'h0000);
    @(negedge clk);
    btn_db = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_strobes", {30'd0, mem_push, mem_pop}, 32'd0);
    chk("rst_mid_regs", alu_a | alu_b | disp_val | 32'(alu_op) | mem_wdata, 32'd0);
    @(negedge clk);
    chk("rst_mid_count", 32'(mem_count), 32'd0);
    do_reset();
    foreach (tbl[i]) begin
      do_cmd(tbl[i].idx, tbl[i].sq, tbl[i].sw);
      chk($sformatf("tbl%0d_disp", i), disp_val, tbl[i].disp);
      chk($sformatf("tbl%0d_alu_a", i), alu_a, tbl[i].a);
      chk($sformatf("tbl%0d_alu_b", i), alu_b, tbl[i].b);
      chk($sformatf("tbl%0d_errs", i), {30'd0, err_under, err_over}, {30'd0, tbl[i].eu, tbl[i].eo});
      chk($sformatf("tbl%0d_count", i), 32'(mem_count), 32'(tbl[i].cnt));
    end
    do_reset();
    for (int i = 0; i < 80; i++) begin
      idx = (i < 9 || $urandom_range(0, 9) < 5) ? 0 : int'($urandom_range(1, 4));
      sq = 1'($urandom_range(0, 1));
      sw = 16'($urandom);
      do_cmd(idx, sq, sw);
      model_cmd(idx, sq, sw);
      chk_state();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
Command sequencer for the stack/queue calculator. It turns debounced button levels into single-shot commands and sequences the shared storage buffer and the combinational ALU through push, pop, execute and write-back. It owns operand ordering for stack and queue modes, and the underflow/overflow error flags. It sits between the debounce stage and the storage buffer and ALU, and drives the display value.

Parameters:
DATA_W, 32, storage/ALU word width
SW_W, 16, switch input width; zero-extended to DATA_W on push
CNT_W, 4, width of storage occupancy count (depth up to 2**CNT_W-1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
btn_db  in  5  debounced buttons: [0]=push switches, [4:1]=ALU ops
stack_queue  in  1  debounced mode: 1=stack (LIFO), 0=queue (FIFO)
switches  in  SW_W  operand entry value
mem_count  in  CNT_W  current storage occupancy
mem_full  in  1  storage full
mem_rdata  in  DATA_W  pop data, valid the cycle after mem_pop
mem_push  out  1  one-cycle push strobe
mem_pop  out  1  one-cycle pop strobe
mem_wdata  out  DATA_W  push data, valid with mem_push
alu_a  out  DATA_W  older-pushed operand
alu_b  out  DATA_W  newer-pushed operand
alu_op  out  4  one-hot op, held from EXEC through WB
alu_y  in  DATA_W  combinational ALU result
disp_val  out  DATA_W  last value written to storage
busy  out  1  command in progress
err_under  out  1  sticky: op requested with mem_count<2
err_over  out  1  sticky: push requested while mem_full

Behaviour:
- Reset: FSM=IDLE; all outputs 0; btn_db history register cleared to 0, so a button held through reset fires once on release of rst.
- Edge detect: rise = btn_db & ~btn_prev, registered every cycle.
- Edges arriving while busy are discarded, not queued.
- Arbitration on simultaneous rises: lowest index wins (push beats ops; op1 beats op2 ...). Losers are dropped.
- stack_queue is sampled at command accept and held for the whole command.
- FSM states: IDLE, PUSH, POP1, POP2, CAP, EXEC, WB, ERR.
- IDLE, push rise, mem_full=0: go to PUSH.
- IDLE, push rise, mem_full=1: go to ERR, set err_over.
- IDLE, op rise, mem_count>=2: go to POP1, latch op.
- IDLE, op rise, mem_count<2: go to ERR, set err_under, no pops issued.
- PUSH: mem_push=1, mem_wdata={zeros,switches}, disp_val<=same; next IDLE.
- POP1: mem_pop=1; next POP2.
- POP2: capture mem_rdata as first popped (P1); mem_pop=1; next CAP.
- CAP: capture mem_rdata as P2; next EXEC.
- Operand order, stack mode: alu_a=P2, alu_b=P1.
- Operand order, queue mode: alu_a=P1, alu_b=P2.
- In both modes alu_a is always the older-pushed value.
- EXEC: alu_a/alu_b/alu_op stable one full cycle; next WB.
- WB: mem_push=1, mem_wdata=alu_y, disp_val<=alu_y; next IDLE.
- Write-back never overflows, because two entries were freed.
- ERR: one cycle, no memory strobes; next IDLE.
- busy=1 in every state except IDLE.
- Latency from rise detected to strobe: push 1 cycle. Op: pops at +1 and +2, write-back at +5; busy for 5 cycles.
- err_under/err_over: sticky; both cleared on entry to PUSH or POP1 (next accepted command).
- alu_a/alu_b hold their last values in IDLE; alu_op returns to 0 in IDLE.
- mem_push and mem_pop are never asserted in the same cycle.
- rst mid-command: abort to IDLE, strobes drop the same cycle. Partial pops are not restored; storage clears on the same rst.

Decomposition:
- Shared package calc_pkg holds the FSM state enum, op one-hot constants (OP_ADD=4'b0001, OP_SUB=4'b0010, OP_AND=4'b0100, OP_OR=4'b1000) and DATA_W/SW_W defaults.
- One sub-module, btn_edge_arb: edge detection, lowest-index priority and busy masking. It outputs a one-cycle command valid plus one-hot command.
- FSM and datapath registers stay in calc_sequencer.

Test Plan:
- rst, then push rise with switches=16'h0005 -> mem_push one cycle later, mem_wdata=32'h5, disp_val=5, busy 1 cycle.
- Stack mode: push 5, push 3, op1 (bench ALU: add=a+b, sub=a-b), then op2 case: push 5, push 3, sub -> alu_a=5, alu_b=3, WB writes 2, disp_val=2, pops at +1/+2, push at +5.
- Queue mode: push 5, push 3, sub -> alu_a=5, alu_b=3 (P1=5); WB writes 2.
- Op with mem_count=1 -> no mem_pop, err_under=1, busy one cycle. Then push -> err_under clears.
- Push with mem_full=1 -> no mem_push, err_over=1.
- btn_db[0] and btn_db[2] rise in the same cycle -> only push executes. A second op rise during busy is ignored. rst asserted in POP2 -> all outputs 0 next cycle, FSM IDLE.
